// File: rtl/fetch_wait_stage_pkg.sv
// Shared definitions for the fetch wait stage: 2-bit FSM encoding, exception codes,
// and the helper that picks the state a freshly accepted entry lands in.
package fetch_wait_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_FULL    = 2'd2,
    ST_DISCARD = 2'd3
  } fw_state_t;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_MOD  = 5'h01;
  localparam logic [4:0] EXC_TLBL = 5'h02;
  localparam logic [4:0] EXC_TLBS = 5'h03;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  // Exception entries never issued a bus read, so a squashed one simply vanishes,
  // while a squashed normal entry must still swallow its returning data.
  function automatic fw_state_t accept_target(input logic exc, input logic squash);
    if (exc) begin
      return squash ? ST_EMPTY : ST_FULL;
    end
    return squash ? ST_DISCARD : ST_WAIT;
  endfunction

endpackage

// File: rtl/fetch_wait_stage.sv
// Fetch wait stage: holds one fetch entry until its instruction word returns, then hands it to decode.
// Define FETCH_WAIT_PERFCNT_EN to enable the wait-for-data performance counter.
module fetch_wait_stage
  import fetch_wait_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic        cancelled_i,
  input  logic        exc_i,
  input  logic        exc_miss_i,
  input  logic [4:0]  exccode_i,
  output logic        ready_o,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        exc_o,
  output logic        exc_miss_o,
  output logic [4:0]  exccode_o,
  input  logic        ready_i,
  input  logic        commit_i,
  output logic [31:0] perfcnt_fetch_waitdata
);

  fw_state_t   state_reg, state_next;
  fw_state_t   accept_state;
  logic [31:0] pc_reg, inst_reg;
  logic        exc_reg, exc_miss_reg;
  logic [4:0]  exccode_reg;
  logic        accept, capture_data;

  always_comb begin
    ready_o = (state_reg == ST_EMPTY) ||
              ((state_reg == ST_FULL) && ready_i) ||
              ((state_reg == ST_DISCARD) && inst_data_ok);
  end

  assign accept       = valid_i && ready_o;
  assign accept_state = accept_target(exc_i, cancelled_i || commit_i);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    capture_data = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        if (accept) state_next = accept_state;
      end
      ST_WAIT: begin
        // A flush wins over returning data; data arriving with the flush is dropped.
        if (commit_i) begin
          state_next = inst_data_ok ? ST_EMPTY : ST_DISCARD;
        end else if (inst_data_ok) begin
          state_next   = ST_FULL;
          capture_data = 1'b1;
        end
      end
      ST_FULL: begin
        if (commit_i || ready_i) state_next = accept ? accept_state : ST_EMPTY;
      end
      ST_DISCARD: begin
        if (inst_data_ok) state_next = accept ? accept_state : ST_EMPTY;
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg       <= 32'd0;
      inst_reg     <= 32'd0;
      exc_reg      <= 1'b0;
      exc_miss_reg <= 1'b0;
      exccode_reg  <= 5'd0;
    end else if (accept) begin
      pc_reg       <= pc_i;
      inst_reg     <= 32'd0;
      exc_reg      <= exc_i;
      exc_miss_reg <= exc_miss_i;
      exccode_reg  <= exccode_i;
    end else if (capture_data) begin
      inst_reg <= inst_rdata;
    end
  end

  assign valid_o    = (state_reg == ST_FULL) && !commit_i;
  assign pc_o       = pc_reg;
  assign inst_o     = inst_reg;
  assign exc_o      = exc_reg;
  assign exc_miss_o = exc_miss_reg;
  assign exccode_o  = exccode_reg;

`ifdef FETCH_WAIT_PERFCNT_EN
  logic [31:0] perfcnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perfcnt_reg <= 32'd0;
    end else if (((state_reg == ST_WAIT) || (state_reg == ST_DISCARD)) && !inst_data_ok) begin
      perfcnt_reg <= perfcnt_reg + 32'd1;
    end
  end

  assign perfcnt_fetch_waitdata = perfcnt_reg;
`else
  assign perfcnt_fetch_waitdata = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_wait_stage.sv
// Randomized scoreboard bench for fetch_wait_stage; the reference tracks outstanding bus reads
// and presentable entries as queues, independent of the stage's internal state machine.
module tb_fetch_wait_stage;
  import fetch_wait_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i, cancelled_i, exc_i, exc_miss_i, ready_o;
  logic [31:0] pc_i;
  logic [4:0]  exccode_i;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        valid_o, exc_o, exc_miss_o, ready_i, commit_i;
  logic [31:0] pc_o, inst_o, perfcnt_fetch_waitdata;
  logic [4:0]  exccode_o;

  fetch_wait_stage dut (
    .clk(clk), .reset(reset),
    .valid_i(valid_i), .pc_i(pc_i), .cancelled_i(cancelled_i), .exc_i(exc_i),
    .exc_miss_i(exc_miss_i), .exccode_i(exccode_i), .ready_o(ready_o),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .valid_o(valid_o), .pc_o(pc_o), .inst_o(inst_o), .exc_o(exc_o),
    .exc_miss_o(exc_miss_o), .exccode_o(exccode_o), .ready_i(ready_i),
    .commit_i(commit_i), .perfcnt_fetch_waitdata(perfcnt_fetch_waitdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic        miss;
    logic [4:0]  code;
  } ent_t;

  ent_t        sb_q[$];   // entries the monitor expects to see on the output
  ent_t        out_q[$];  // reference: entries currently presentable
  bit          rd_pending, rd_alive;
  ent_t        rd_ent;
  logic [31:0] exp_perf;
  ent_t        mon_h;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    out_q.delete();
    sb_q.delete();
    rd_pending = 0;
    rd_alive   = 0;
    exp_perf   = 32'd0;
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic canc, input logic exc,
                      input logic miss, input logic [4:0] code, input logic cmt, input logic dok,
                      input logic [31:0] rd, input logic rdy);
    bit   exp_valid, exp_ready;
    ent_t e;
    @(negedge clk);
    valid_i = v; pc_i = pc; cancelled_i = canc; exc_i = exc; exc_miss_i = miss;
    exccode_i = code; commit_i = cmt; inst_data_ok = dok; inst_rdata = rd; ready_i = rdy;
    #1;
    chk("perfcnt", perfcnt_fetch_waitdata, exp_perf);
    exp_valid = (out_q.size() > 0) && !cmt;
    exp_ready = (!rd_pending && out_q.size() == 0) || (out_q.size() > 0 && rdy) ||
                (rd_pending && !rd_alive && dok);
    chk("valid_o", {31'd0, valid_o}, {31'd0, exp_valid});
    chk("ready_o", {31'd0, ready_o}, {31'd0, exp_ready});
`ifdef FETCH_WAIT_PERFCNT_EN
    if (rd_pending && !dok) exp_perf = exp_perf + 32'd1;
`endif
    if (exp_valid && rdy) void'(out_q.pop_front());
    if (cmt) begin
      out_q.delete();
      sb_q.delete();
      rd_alive = 0;
    end
    if (rd_pending && dok) begin
      rd_pending = 0;
      if (rd_alive) begin
        e = rd_ent;
        e.inst = rd;
        out_q.push_back(e);
        sb_q.push_back(e);
      end
    end
    if (exp_ready && v) begin
      e.pc = pc; e.inst = 32'd0; e.exc = exc; e.miss = miss; e.code = code;
      if (exc) begin
        if (!(canc || cmt)) begin
          out_q.push_back(e);
          sb_q.push_back(e);
        end
      end else begin
        rd_pending = 1;
        rd_alive   = !(canc || cmt);
        rd_ent     = e;
      end
    end
  endtask

  task automatic idle(input logic dok, input logic [31:0] rd, input logic rdy);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, dok, rd, rdy);
  endtask

  task automatic rand_step();
    logic dok;
    dok = rd_pending ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) < 3);
    step($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) == 0,
         $urandom_range(0, 99) < 15, 1'($urandom), 5'($urandom), $urandom_range(0, 99) < 8,
         dok, $urandom, $urandom_range(0, 9) < 7);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    valid_i = 0; commit_i = 0; inst_data_ok = 0; ready_i = 0;
    #2 reset = 1'b1;
    #1;
    chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
    chk("rst_pc_o", pc_o, 32'd0);
    chk("rst_perfcnt", perfcnt_fetch_waitdata, 32'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compares the presented entry every cycle and retires it on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!reset && valid_o) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_empty: valid_o=1 pc_o=%h, required no entry", pc_o);
        end else begin
          mon_h = sb_q[0];
          chk("pc_o", pc_o, mon_h.pc);
          chk("inst_o", inst_o, mon_h.inst);
          chk("exc_o", {31'd0, exc_o}, {31'd0, mon_h.exc});
          chk("exc_miss_o", {31'd0, exc_miss_o}, {31'd0, mon_h.miss});
          chk("exccode_o", {27'd0, exccode_o}, {27'd0, mon_h.code});
          if (ready_i) begin
            $display("[TB] retire pc=%h inst=%h exc=%0d code=%0d", pc_o, inst_o, exc_o, exccode_o);
            void'(sb_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    valid_i = 0; pc_i = 0; cancelled_i = 0; exc_i = 0; exc_miss_i = 0; exccode_i = 0;
    inst_data_ok = 0; inst_rdata = 0; ready_i = 0; commit_i = 0;
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_valid_o", {31'd0, valid_o}, 32'd0);
    chk("reset_pc_o", pc_o, 32'd0);
    chk("reset_inst_o", inst_o, 32'd0);
    chk("reset_exc", {25'd0, exc_o, exc_miss_o, exccode_o}, 32'd0);
    chk("reset_perfcnt", perfcnt_fetch_waitdata, 32'd0);
    chk("reset_ready_o", {31'd0, ready_o}, 32'd1);

    // Normal fetch: data two cycles after accept.
    step(1, 32'hBFC00000, 0, 0, 0, 5'd0, 0, 0, 32'd0, 1);
    idle(0, 32'd0, 1);
    idle(1, 32'h3C08BFC0, 1);
    idle(0, 32'd0, 1);
    // Backpressure for 5 cycles, then retire and accept in the same cycle.
    step(1, 32'hBFC00004, 0, 0, 0, 5'd0, 0, 0, 32'd0, 0);
    idle(1, 32'h24080001, 0);
    repeat (5) idle(0, 32'd0, 0);
    step(1, 32'hBFC00008, 0, 0, 0, 5'd0, 0, 0, 32'd0, 1);
    idle(1, 32'h00000000, 1);
    idle(0, 32'd0, 1);
    // Flush while waiting; the late data must never surface.
    step(1, 32'h80001000, 0, 0, 0, 5'd0, 0, 0, 32'd0, 1);
    step(0, 32'd0, 0, 0, 0, 5'd0, 1, 0, 32'd0, 1);
    idle(1, 32'h12345678, 1);
    repeat (2) idle(0, 32'd0, 1);
    // Exception entry needs no bus data.
    step(1, 32'h00000002, 0, 1, 0, EXC_ADEL, 0, 0, 32'd0, 1);
    repeat (2) idle(0, 32'd0, 1);
    // Cancelled entry; its data returns alongside a new request.
    step(1, 32'h80002000, 1, 0, 0, 5'd0, 0, 0, 32'd0, 1);
    step(1, 32'h80002004, 0, 0, 0, 5'd0, 0, 1, 32'hDEADBEEF, 1);
    idle(1, 32'h8C020010, 1);
    idle(0, 32'd0, 1);
    // Long wait exercises the perf counter.
    step(1, 32'h80003000, 0, 0, 0, 5'd0, 0, 0, 32'd0, 1);
    repeat (7) idle(0, 32'd0, 1);
    idle(1, 32'hAC030000, 1);
    idle(0, 32'd0, 1);
    // Reset in the middle of a wait, then a stray data return.
    step(1, 32'h80004000, 0, 0, 0, 5'd0, 0, 0, 32'd0, 1);
    idle(0, 32'd0, 1);
    mid_reset();
    idle(1, 32'hCAFEF00D, 1);
    repeat (2) idle(0, 32'd0, 1);

    repeat (2000) rand_step();

    for (int i = 0; i < 20; i++) begin
      if (!rd_pending && out_q.size() == 0) break;
      idle(rd_pending, $urandom, 1);
    end
    idle(0, 32'd0, 1);
    #2;
    chk("drain_valid_o", {31'd0, valid_o}, 32'd0);
    chk("drain_sb_left", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
